// File: rtl/c2h_frame_arbiter_pkg.sv
// Shared constants and FSM state type for the C2H frame arbiter.
package c2h_pkg;
  localparam int FRAME_W         = 4072;
  localparam int BEAT_W          = 512;
  localparam int BEATS_PER_FRAME = (FRAME_W + BEAT_W - 1) / BEAT_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ABORT  = 3'd4
  } c2h_arb_state_t;
endpackage

// File: rtl/c2h_frame_arbiter_if.sv
// Producer request bundle, writer launch/completion signals and arbiter status.
interface c2h_frame_arbiter_if
  import c2h_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FRAME_W = c2h_pkg::FRAME_W
);
  localparam int GW = $clog2(N_REQ);

  // Handshake: req_valid[i] is held with stable req_data until the arbiter pulses
  // req_done[i]; wr_data_valid is a one-cycle launch, wr_data_next a one-cycle completion.
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*FRAME_W-1:0] req_data;
  logic [N_REQ-1:0]         req_done;
  logic                     wr_data_valid;
  logic [FRAME_W-1:0]       wr_data;
  logic                     wr_data_next;
  logic                     wr_abort;
  logic                     busy;
  logic [GW-1:0]            grant_id;
  logic [31:0]              frame_count;
  logic                     timeout_err;
  c2h_arb_state_t           state;

  modport master (
    input  req_valid, req_data, wr_data_next,
    output req_done, wr_data_valid, wr_data, wr_abort, busy, grant_id,
           frame_count, timeout_err, state
  );

  modport slave (
    output req_valid, req_data, wr_data_next,
    input  req_done, wr_data_valid, wr_data, wr_abort, busy, grant_id,
           frame_count, timeout_err, state
  );
endinterface

// File: rtl/c2h_frame_arbiter_rr_pick.sv
// Combinational round-robin pick: first pending request after i_last, with wrap.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic [$clog2(N_REQ)-1:0] o_sel,
  output logic                     o_any
);
  localparam int GW = $clog2(N_REQ);

  int w_idx;

  // Scan from the farthest offset down so the nearest pending request wins.
  always_comb begin
    o_sel = i_last;
    o_any = 1'b0;
    w_idx = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      w_idx = int'(i_last) + off;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (i_req[w_idx]) begin
        o_sel = GW'(w_idx);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/c2h_frame_arbiter.sv
// Round-robin scheduler sharing one C2H frame writer among N_REQ producers,
// with a watchdog that aborts the writer when a frame stalls.
module c2h_frame_arbiter
  import c2h_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FRAME_W = c2h_pkg::FRAME_W,
  parameter int TIMEOUT = 1024
) (
  input logic                m_axis_c2h_aclk,
  input logic                m_axis_c2h_areset,
  c2h_frame_arbiter_if.master bus
);
  localparam int              GW      = $clog2(N_REQ);
  localparam int              WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [GW-1:0]   LAST_ID = GW'(N_REQ - 1);

  c2h_arb_state_t   r_state, w_state_nxt;
  logic [GW-1:0]    r_grant, w_grant_nxt;
  logic [GW-1:0]    r_last,  w_last_nxt;
  logic [WDW-1:0]   r_wd,    w_wd_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_abort, w_abort_nxt;
  logic             r_err,   w_err_nxt;
  logic [N_REQ-1:0] r_done,  w_done_nxt;
  logic [31:0]      r_count, w_count_nxt;
  logic [GW-1:0]    w_sel;
  logic             w_any;
  logic [FRAME_W-1:0] w_wr_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_sel  (w_sel),
    .o_any  (w_any)
  );

  always_ff @(posedge m_axis_c2h_aclk or posedge m_axis_c2h_areset) begin
    if (m_axis_c2h_areset) begin
      r_state <= S_IDLE;
      r_grant <= LAST_ID;
      r_last  <= LAST_ID;
      r_wd    <= '0;
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_wd    <= w_wd_nxt;
      r_valid <= w_valid_nxt;
      r_abort <= w_abort_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Pulse outputs default low so each is high for exactly the one state after its set.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_wd_nxt    = r_wd;
    w_valid_nxt = 1'b0;
    w_abort_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_done_nxt  = '0;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_sel;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_wd_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.wr_data_next) begin
          w_done_nxt[r_grant] = 1'b1;
          w_count_nxt         = r_count + 32'd1;
          w_last_nxt          = r_grant;
          w_state_nxt         = S_DONE;
        end else if (r_wd == WD_LAST) begin
          w_abort_nxt = 1'b1;
          w_err_nxt   = 1'b1;
          w_last_nxt  = r_grant;
          w_state_nxt = S_ABORT;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == GW'(i)) w_wr_data = bus.req_data[i*FRAME_W +: FRAME_W];
    end
  end

  assign bus.wr_data       = w_wr_data;
  assign bus.wr_data_valid = r_valid;
  assign bus.wr_abort      = r_abort;
  assign bus.req_done      = r_done;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.grant_id      = r_grant;
  assign bus.frame_count   = r_count;
  assign bus.timeout_err   = r_err;
  assign bus.state         = r_state;
endmodule

// File: tb/tb_c2h_frame_arbiter.sv
// Scenario bench for c2h_frame_arbiter: expected grants queued at stimulus time,
// popped and compared when the arbiter launches a frame.
module tb_c2h_frame_arbiter;
  import c2h_pkg::*;

  localparam int N_REQ   = 4;
  localparam int FW      = c2h_pkg::FRAME_W;
  localparam int TIMEOUT = 32;
  localparam int GW      = $clog2(N_REQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [GW-1:0] exp_q[$];
  logic [FW-1:0] frames [N_REQ];

  c2h_frame_arbiter_if #(.N_REQ(N_REQ), .FRAME_W(FW)) bus ();

  c2h_frame_arbiter #(.N_REQ(N_REQ), .FRAME_W(FW), .TIMEOUT(TIMEOUT)) dut (
    .m_axis_c2h_aclk   (clk),
    .m_axis_c2h_areset (rst),
    .bus               (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_frame(input int i, input logic [FW-1:0] f);
    frames[i] = f;
    bus.req_data[i*FW +: FW] = f;
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int w = 0; w < (FW + 31) / 32; w++) f = (f << 32) | FW'($urandom());
    return f;
  endfunction

  task automatic apply_reset();
    bus.req_valid    = '0;
    bus.wr_data_next = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  // Waits (bounded) for a launch, plays the writer with lat cycles of latency,
  // and returns what was observed. cyc = -1 means no launch was seen.
  task automatic launch_and_serve(input int lat, input bit drop, output int cyc,
                                  output logic [GW-1:0] gid, output logic [FW-1:0] dat,
                                  output logic [N_REQ-1:0] done, output logic va);
    gid = '0; dat = '0; done = '0; va = 1'b1; cyc = 0;
    do begin tick(); cyc++; end while (bus.wr_data_valid !== 1'b1 && cyc < 64);
    if (bus.wr_data_valid !== 1'b1) begin
      cyc = -1;
      return;
    end
    gid = bus.grant_id;
    dat = bus.wr_data;
    tick();
    va = bus.wr_data_valid;
    repeat (lat - 1) tick();
    bus.wr_data_next = 1'b1;
    tick();
    done = bus.req_done;
    bus.wr_data_next = 1'b0;
    if (drop) bus.req_valid[gid] = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] got, want;
    apply_reset();
    got  = {bus.wr_data_valid, bus.wr_abort, bus.busy, bus.timeout_err, bus.req_done,
            bus.grant_id, bus.frame_count};
    want = {4'b0000, 4'b0000, 2'd3, 32'd0};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", got, want);
    end
    n_vec++;
    if (bus.state !== S_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", bus.state, S_IDLE);
    end
  endtask

  task automatic test_single();
    int cyc;
    logic [GW-1:0] gid, exp;
    logic [FW-1:0] dat, a5;
    logic [N_REQ-1:0] done;
    logic va;
    a5 = {509{8'hA5}};
    set_frame(0, a5);
    bus.req_valid = 4'b0001;
    exp_q.push_back(2'd0);
    launch_and_serve(3, 1'b1, cyc, gid, dat, done, va);
    exp = exp_q.pop_front();
    n_vec++;
    if (cyc !== 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1", cyc); end
    n_vec++;
    if (gid !== exp) begin n_bad++; $display("FAIL single_grant: got %0d want %0d", gid, exp); end
    n_vec++;
    if (dat !== frames[exp]) begin
      n_bad++;
      $display("FAIL single_data: got %h want %h (low 64 bits)", dat[63:0], frames[exp][63:0]);
    end
    n_vec++;
    if (va !== 1'b0) begin n_bad++; $display("FAIL single_valid_width: got %b want 0", va); end
    n_vec++;
    if (done !== 4'b0001) begin n_bad++; $display("FAIL single_done: got %b want 0001", done); end
    tick();
    n_vec++;
    if ({bus.req_done, bus.busy, bus.frame_count} !== {4'b0000, 1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL single_after: done %b busy %b count %0d want 0000 0 1",
               bus.req_done, bus.busy, bus.frame_count);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [GW-1:0] gid, exp;
    logic [FW-1:0] dat;
    logic [N_REQ-1:0] done, oh;
    logic va;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) set_frame(i, rand_frame());
    bus.req_valid = 4'b1111;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int k = 0; k < 5; k++) begin
      launch_and_serve($urandom_range(1, 6), 1'b0, cyc, gid, dat, done, va);
      exp = exp_q.pop_front();
      oh = '0;
      oh[exp] = 1'b1;
      n_vec++;
      if (cyc <= 0 || gid !== exp) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %0d want %0d (wait %0d)", k, gid, exp, cyc);
      end
      n_vec++;
      if (dat !== frames[exp]) begin
        n_bad++;
        $display("FAIL rr_data[%0d]: got %h want %h (low 64 bits)", k, dat[63:0], frames[exp][63:0]);
      end
      n_vec++;
      if (done !== oh) begin n_bad++; $display("FAIL rr_done[%0d]: got %b want %b", k, done, oh); end
      set_frame(int'(exp), rand_frame());
    end
    bus.req_valid = '0;
    tick();
    n_vec++;
    if (bus.frame_count !== 32'd5) begin
      n_bad++;
      $display("FAIL rr_count: got %0d want 5", bus.frame_count);
    end
  endtask

  task automatic test_fairness();
    int cyc;
    logic [GW-1:0] gid, exp;
    logic [FW-1:0] dat;
    logic [N_REQ-1:0] done;
    logic va;
    apply_reset();
    bus.req_valid = 4'b0100;
    exp_q.push_back(2'd2);
    launch_and_serve(2, 1'b1, cyc, gid, dat, done, va);
    exp = exp_q.pop_front();
    n_vec++;
    if (cyc <= 0 || gid !== exp) begin n_bad++; $display("FAIL fair_setup: got %0d want %0d", gid, exp); end
    bus.req_valid = 4'b0101;
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    for (int k = 0; k < 2; k++) begin
      launch_and_serve($urandom_range(1, 4), 1'b1, cyc, gid, dat, done, va);
      exp = exp_q.pop_front();
      n_vec++;
      if (cyc <= 0 || gid !== exp) begin
        n_bad++;
        $display("FAIL fair_grant[%0d]: got %0d want %0d", k, gid, exp);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, first, pulses;
    bit saw_done;
    logic [GW-1:0] gid, exp;
    logic [FW-1:0] dat;
    logic [N_REQ-1:0] done, oh;
    logic va;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) set_frame(i, rand_frame());
    bus.req_valid = 4'b0111;
    exp_q.push_back(2'd0);
    cyc = 0;
    do begin tick(); cyc++; end while (bus.wr_data_valid !== 1'b1 && cyc < 64);
    exp = exp_q.pop_front();
    n_vec++;
    if (bus.wr_data_valid !== 1'b1 || bus.grant_id !== exp) begin
      n_bad++;
      $display("FAIL to_launch: valid %b grant %0d want 1 %0d", bus.wr_data_valid, bus.grant_id, exp);
    end
    first = -1; pulses = 0; saw_done = 1'b0;
    for (int c = 1; c <= TIMEOUT + 2; c++) begin
      tick();
      if (bus.wr_abort === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (bus.req_done !== '0) saw_done = 1'b1;
    end
    n_vec++;
    if (first !== TIMEOUT + 1 || pulses !== 1) begin
      n_bad++;
      $display("FAIL to_abort: first %0d pulses %0d want %0d 1", first, pulses, TIMEOUT + 1);
    end
    n_vec++;
    if ({saw_done, bus.timeout_err, bus.frame_count} !== {1'b0, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL to_status: done_seen %b err %b count %0d want 0 1 0",
               saw_done, bus.timeout_err, bus.frame_count);
    end
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd0);
    for (int k = 0; k < 3; k++) begin
      launch_and_serve($urandom_range(1, 5), 1'b1, cyc, gid, dat, done, va);
      exp = exp_q.pop_front();
      oh = '0;
      oh[exp] = 1'b1;
      n_vec++;
      if (cyc <= 0 || gid !== exp || done !== oh) begin
        n_bad++;
        $display("FAIL to_retry[%0d]: grant %0d done %b want %0d %b", k, gid, done, exp, oh);
      end
    end
    n_vec++;
    if ({bus.timeout_err, bus.frame_count} !== {1'b1, 32'd3}) begin
      n_bad++;
      $display("FAIL to_sticky: err %b count %0d want 1 3", bus.timeout_err, bus.frame_count);
    end
  endtask

  task automatic test_race();
    int cyc;
    bit saw_abort;
    logic [GW-1:0] gid, exp;
    logic [FW-1:0] dat;
    logic [N_REQ-1:0] done;
    logic va;
    apply_reset();
    bus.req_valid = 4'b0010;
    exp_q.push_back(2'd1);
    launch_and_serve(TIMEOUT, 1'b1, cyc, gid, dat, done, va);
    exp = exp_q.pop_front();
    saw_abort = (bus.wr_abort === 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.wr_abort === 1'b1) saw_abort = 1'b1;
    end
    n_vec++;
    if (cyc <= 0 || gid !== exp || done !== 4'b0010) begin
      n_bad++;
      $display("FAIL race_done: grant %0d done %b want %0d 0010", gid, done, exp);
    end
    n_vec++;
    if ({saw_abort, bus.timeout_err, bus.frame_count} !== {1'b0, 1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL race_status: abort_seen %b err %b count %0d want 0 0 1",
               saw_abort, bus.timeout_err, bus.frame_count);
    end
  endtask

  task automatic test_ignore_next();
    bit saw_done;
    saw_done = 1'b0;
    bus.wr_data_next = 1'b1;
    repeat (3) begin
      tick();
      if (bus.req_done !== '0) saw_done = 1'b1;
    end
    bus.wr_data_next = 1'b0;
    tick();
    n_vec++;
    if ({saw_done, bus.busy, bus.frame_count} !== {1'b0, 1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL idle_next: done_seen %b busy %b count %0d want 0 0 1",
               saw_done, bus.busy, bus.frame_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    bit saw_done;
    logic [GW-1:0] gid;
    logic [FW-1:0] dat;
    logic [N_REQ-1:0] done;
    logic va;
    logic [41:0] got, want;
    apply_reset();
    bus.req_valid = 4'b0001;
    launch_and_serve(2, 1'b0, cyc, gid, dat, done, va);
    cyc = 0;
    do begin tick(); cyc++; end while (bus.wr_data_valid !== 1'b1 && cyc < 64);
    repeat (5) tick();
    n_vec++;
    if (bus.state !== S_WAIT || bus.frame_count !== 32'd1) begin
      n_bad++;
      $display("FAIL rst_setup: state %0d count %0d want %0d 1", bus.state, bus.frame_count, S_WAIT);
    end
    rst = 1'b1;
    #1;
    got  = {bus.wr_data_valid, bus.wr_abort, bus.busy, bus.timeout_err, bus.req_done,
            bus.grant_id, bus.frame_count};
    want = {4'b0000, 4'b0000, 2'd3, 32'd0};
    n_vec++;
    if (got !== want) begin n_bad++; $display("FAIL rst_mid_wait: got %h want %h", got, want); end
    bus.req_valid = '0;
    bus.wr_data_next = 1'b1;
    tick();
    bus.wr_data_next = 1'b0;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      tick();
      if (bus.req_done !== '0) saw_done = 1'b1;
    end
    n_vec++;
    if ({saw_done, bus.frame_count, bus.state} !== {1'b0, 32'd0, S_IDLE}) begin
      n_bad++;
      $display("FAIL rst_after: done_seen %b count %0d state %0d want 0 0 %0d",
               saw_done, bus.frame_count, bus.state, S_IDLE);
    end
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.wr_data_next = 1'b0;
    for (int i = 0; i < N_REQ; i++) frames[i] = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_race();
    test_ignore_next();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/c2h_frame_arbiter.md
# c2h_frame_arbiter

Round-robin scheduler that shares the single C2H AXI-Stream frame writer between N_REQ frame producers. It arbitrates among pending 4072-bit frames and launches the granted frame into the writer with a one-cycle `data_valid` pulse. It then waits for the writer's `data_next` completion pulse and acknowledges the owning producer. A watchdog aborts the writer through its `en` clear input if a frame stalls.

## Interface
- `N_REQ`, 4: number of producers; range 2..8.
- `FRAME_W`, 4072: frame width in bits; must match the writer's `data` width.
- `TIMEOUT`, 1024: cycles allowed in WAIT before abort; ≥ 32.
- `m_axis_c2h_aclk` in 1: clock, shared with the writer.
- `m_axis_c2h_areset` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: producer i has a frame pending; held until `req_done[i]`.
- `req_data` in N_REQ*FRAME_W: frame of producer i at bits [i*FRAME_W +: FRAME_W]; stable while `req_valid[i]`.
- `req_done` out N_REQ: one-cycle pulse, frame i fully sent.
- `wr_data_valid` out 1: to writer `data_valid`.
- `wr_data` out FRAME_W: to writer `data`.
- `wr_data_next` in 1: from writer `data_next`.
- `wr_abort` out 1: to writer `en`; synchronous clear of the writer.
- `busy` out 1: state ≠ IDLE.
- `grant_id` out clog2(N_REQ): current or last granted producer.
- `frame_count` out 32: completed frames; wraps 0xFFFFFFFF→0.
- `timeout_err` out 1: sticky; set on abort, cleared only by reset.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, ABORT.
- IDLE:
  - If any `req_valid`, select the first set bit scanning from (last_grant+1) mod N_REQ upward with wrap.
  - On selection: `grant_id`←sel, `wr_data_valid`←1, → LAUNCH.
  - With no request, stay in IDLE.
- LAUNCH: `wr_data_valid`←0, clear watchdog, → WAIT.
- WAIT:
  - If `wr_data_next`: `req_done[grant_id]`←1, `frame_count`+1, last_grant←grant_id, → DONE.
  - Else if watchdog = TIMEOUT-1: `wr_abort`←1, `timeout_err`←1, last_grant←grant_id, → ABORT.
  - Otherwise the watchdog increments.
- DONE: `req_done`←0, → IDLE.
- ABORT: `wr_abort`←0, → IDLE.
  - No `req_done` is issued; the producer stays pending and is retried after the other requesters by round-robin order.
- `wr_data` = `req_data` slice selected by `grant_id` (combinational mux).
  - The writer latches it during the LAUNCH cycle.
- `wr_data_next` outside WAIT is ignored; it does not count as a frame.
- Producer rule: drop `req_valid[i]` at the clock edge that samples `req_done[i]`=1, or re-raise it with a new frame at the following IDLE.

## Timing
- Reset values:
  - state IDLE; `wr_data_valid`, `wr_abort`, `req_done`, `busy`, `timeout_err` = 0.
  - `grant_id` = N_REQ-1; last_grant = N_REQ-1, so producer 0 wins first.
  - `frame_count` = 0; watchdog = 0.
- Request to launch: `req_valid` seen in IDLE at edge k gives `wr_data_valid` high for exactly cycle k+1.
- Completion: `wr_data_next` high in WAIT at edge m gives `req_done` high for cycle m+1 and IDLE at m+2.
  - Minimum frame-to-frame gap is 4 controller cycles plus writer time.
- Timeout: abort asserts TIMEOUT cycles after entering WAIT; `wr_abort` is high for exactly 1 cycle.
- `wr_data_next` and timeout in the same cycle: completion wins; no abort, no error.
- Reset asserted mid-WAIT:
  - All outputs return to reset values immediately.
  - The writer is reset by its own reset; the in-flight frame is lost and is not acknowledged.
- All outputs are registered except `wr_data` and `busy`.

## Structure
- Package `c2h_pkg`: `FRAME_W`=4072, beats per frame = 8 (4072/512 rounded up), state enum `c2h_arb_state_t`.
- Sub-module `rr_pick`:
  - Combinational round-robin select from (`req_valid`, last_grant) to (sel, any).
  - Parameterised by N_REQ.

## Test plan
- Single request: `req_valid`=0001 with frame 0xA5… → one `wr_data_valid` pulse; `req_done`=0001 after writer `data_next`; `frame_count`=1.
- Simultaneous requests: `req_valid`=1111 held → grant order 0,1,2,3,0; each `req_done` exactly once per frame.
- Fairness after wrap: last_grant=2, `req_valid`=0101 → grant 0 before 2.
- Timeout: writer `data_next` stuck low, TIMEOUT=32 → `wr_abort` pulse 32 cycles after WAIT entry; `timeout_err`=1; the stalled producer is re-granted after the others.
- Race: `wr_data_next` coincides with watchdog = TIMEOUT-1 → `req_done` asserted, `timeout_err` stays 0.
- Reset mid-WAIT: assert `m_axis_c2h_areset` → all outputs at reset values the same cycle; no `req_done`; `frame_count`=0.
